// File: rtl/hazard_pkg.sv
// Shared constants and types for the decode-stage hazard controller.
// No logic; imported by the interface, the divider sequencer and the top.
package hazard_pkg;
    localparam int REG_AW_DEFAULT = 6;
    localparam int HI_ADDR        = 32;
    localparam int LO_ADDR        = 33;

    typedef logic [REG_AW_DEFAULT-1:0] reg_addr_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: operand/destination info in, stall/bubble/divider status out.
// Optional perf counters appear only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if #(
    parameter int REG_AW = hazard_pkg::REG_AW_DEFAULT
);
    localparam int NREGS = 1 << REG_AW;

    logic              id_rs_en;
    logic [REG_AW-1:0] id_rs_addr;
    logic              id_rt_en;
    logic [REG_AW-1:0] id_rt_addr;
    logic              id_is_div;
    logic              ex_reg_en;
    logic [REG_AW-1:0] ex_reg_addr;
    logic              ex_is_load;
    logic              mem_reg_en;
    logic [REG_AW-1:0] mem_reg_addr;
    logic              mem_is_load;
    logic              div_start;
    logic [NREGS-1:0]  div_dest;
    logic              dcache_miss;
    logic              flush;

    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;
    logic              stall_ex;
    logic              stall_mem;
    logic              div_busy;
    logic              div_done;
`ifdef HAZARD_PERF_EN
    logic [31:0]       perf_lu_stalls;
    logic [31:0]       perf_div_stalls;
    logic [31:0]       perf_miss_cycles;
`endif

    modport master (
        output id_rs_en, id_rs_addr, id_rt_en, id_rt_addr, id_is_div,
               ex_reg_en, ex_reg_addr, ex_is_load,
               mem_reg_en, mem_reg_addr, mem_is_load,
               div_start, div_dest, dcache_miss, flush,
        input  stall_if, stall_id, bubble_ex, stall_ex, stall_mem, div_busy, div_done
`ifdef HAZARD_PERF_EN
        , perf_lu_stalls, perf_div_stalls, perf_miss_cycles
`endif
    );

    modport slave (
        input  id_rs_en, id_rs_addr, id_rt_en, id_rt_addr, id_is_div,
               ex_reg_en, ex_reg_addr, ex_is_load,
               mem_reg_en, mem_reg_addr, mem_is_load,
               div_start, div_dest, dcache_miss, flush,
        output stall_if, stall_id, bubble_ex, stall_ex, stall_mem, div_busy, div_done
`ifdef HAZARD_PERF_EN
        , perf_lu_stalls, perf_div_stalls, perf_miss_cycles
`endif
    );
endinterface

// File: rtl/div_sequencer.sv
// Iterative-divider tracker: IDLE/BUSY FSM, down-counter and pending-write scoreboard.
// Latency: div_done pulses DIV_CYCLES cycles after div_start; scoreboard clears on the following edge.
// No backpressure: div_start while BUSY is ignored; flush/reset abort the divide.
module div_sequencer
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int NREGS      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_div_start,
    input  logic [NREGS-1:0] i_div_dest,
    output logic [NREGS-1:0] o_pending,
    output logic             o_div_busy,
    output logic             o_div_done
);
    localparam int CNT_W = $clog2(DIV_CYCLES);

    div_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [NREGS-1:0] r_pending, w_pending_nxt;
    logic             w_last;

    assign w_last = (r_state == BUSY) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending;
        if (i_flush) begin
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_pending_nxt = '0;
        end else if (r_state == IDLE) begin
            if (i_div_start) begin
                w_state_nxt   = BUSY;
                w_cnt_nxt     = CNT_W'(DIV_CYCLES - 1);
                // $zero can never be pending
                w_pending_nxt = r_pending | (i_div_dest & ~NREGS'(1));
            end
        end else begin
            if (w_last) begin
                w_state_nxt   = IDLE;
                w_pending_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_pending  = r_pending;
    assign o_div_busy = rst_n && (r_state == BUSY);
    assign o_div_done = rst_n && !i_flush && w_last;
endmodule

// File: rtl/hazard_ctrl.sv
// Decode interlock: load-use, divider scoreboard/structural hazards and cache-miss freeze; HAZARD_PERF_EN adds stall counters.
// Latency: stall/bubble outputs are combinational; divider state updates on the clock edge.
// Backpressure: flush/reset force all stalls low, dcache_miss freezes all stages and masks hazard stalls.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES   = 32,
    parameter int MEM_LOAD_FWD = 1,
    parameter int REG_AW       = REG_AW_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);
    localparam int   NREGS     = 1 << REG_AW;
    localparam logic MEM_STALL = (MEM_LOAD_FWD == 0);

    logic [NREGS-1:0] w_pending;
    logic             w_div_busy, w_div_done;
    logic             w_rs_hit, w_rt_hit, w_ex_ld, w_mem_ld;
    logic             w_lu, w_sb, w_struct, w_hazard, w_active;
    logic             w_stall_if, w_stall_id, w_bubble_ex, w_stall_ex, w_stall_mem;

    div_sequencer #(
        .DIV_CYCLES (DIV_CYCLES),
        .NREGS      (NREGS)
    ) u_div_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (bus.flush),
        .i_div_start (bus.div_start),
        .i_div_dest  (bus.div_dest),
        .o_pending   (w_pending),
        .o_div_busy  (w_div_busy),
        .o_div_done  (w_div_done)
    );

    assign w_rs_hit = bus.id_rs_en && (bus.id_rs_addr != '0);
    assign w_rt_hit = bus.id_rt_en && (bus.id_rt_addr != '0);
    assign w_ex_ld  = bus.ex_reg_en && bus.ex_is_load;
    assign w_mem_ld = MEM_STALL && bus.mem_reg_en && bus.mem_is_load;

    assign w_lu = (w_rs_hit && ((w_ex_ld  && (bus.ex_reg_addr  == bus.id_rs_addr)) ||
                                (w_mem_ld && (bus.mem_reg_addr == bus.id_rs_addr)))) ||
                  (w_rt_hit && ((w_ex_ld  && (bus.ex_reg_addr  == bus.id_rt_addr)) ||
                                (w_mem_ld && (bus.mem_reg_addr == bus.id_rt_addr))));
    // Pending bits stay set through the div_done cycle, so ID is released one cycle later
    assign w_sb     = (w_rs_hit && w_pending[bus.id_rs_addr]) ||
                      (w_rt_hit && w_pending[bus.id_rt_addr]);
    assign w_struct = bus.id_is_div && w_div_busy;
    assign w_hazard = w_lu || w_sb || w_struct;
    assign w_active = rst_n && !bus.flush;

    always_comb begin
        w_stall_if  = 1'b0;
        w_stall_id  = 1'b0;
        w_bubble_ex = 1'b0;
        w_stall_ex  = 1'b0;
        w_stall_mem = 1'b0;
        if (w_active) begin
            if (bus.dcache_miss) begin
                w_stall_if  = 1'b1;
                w_stall_id  = 1'b1;
                w_stall_ex  = 1'b1;
                w_stall_mem = 1'b1;
            end else begin
                w_stall_if  = w_hazard;
                w_stall_id  = w_hazard;
                w_bubble_ex = w_hazard;
            end
        end
    end

    assign bus.stall_if  = w_stall_if;
    assign bus.stall_id  = w_stall_id;
    assign bus.bubble_ex = w_bubble_ex;
    assign bus.stall_ex  = w_stall_ex;
    assign bus.stall_mem = w_stall_mem;
    assign bus.div_busy  = w_div_busy;
    assign bus.div_done  = w_div_done;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_lu, r_perf_div, r_perf_miss;
    logic        w_hz_live;

    assign w_hz_live = w_active && !bus.dcache_miss;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_lu   <= '0;
            r_perf_div  <= '0;
            r_perf_miss <= '0;
        end else begin
            if (w_hz_live && w_lu && !(&r_perf_lu))
                r_perf_lu <= r_perf_lu + 32'd1;
            if (w_hz_live && (w_sb || w_struct) && !(&r_perf_div))
                r_perf_div <= r_perf_div + 32'd1;
            if (w_active && bus.dcache_miss && !(&r_perf_miss))
                r_perf_miss <= r_perf_miss + 32'd1;
        end
    end

    assign bus.perf_lu_stalls   = r_perf_lu;
    assign bus.perf_div_stalls  = r_perf_div;
    assign bus.perf_miss_cycles = r_perf_miss;
`endif
endmodule
